// File: rtl/remap_pkg.sv
// Shared types and helpers for the remap front end: FSM states, frame counter
// width and the line-geometry helper.
package remap_pkg;

  localparam int FRAME_CNT_W = 16;

  typedef enum logic [2:0] {
    WAIT_SOF,
    PASS,
    PAD_LINE,
    DROP,
    PAD_FRAME
  } state_t;

  function automatic int beats_per_line(input int cols, input int pixel_width, input int dwidth);
    return cols * pixel_width / dwidth;
  endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// One-stage AXI4-Stream register (tdata/tlast/tuser). Accepts whenever the
// slot is empty or being drained, so a continuous stream runs at full rate.
module axis_pipe_reg #(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          in_user,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_user
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_user  <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
        out_last <= in_last;
        out_user <= in_user;
      end
    end
  end

endmodule

// File: rtl/remap_frame_sync.sv
// Forces a raw video stream into frames of exactly ROWS x BEATS_PER_LINE beats:
// pads short lines/frames with zeros, truncates long lines, drops stray beats.
module remap_frame_sync
  import remap_pkg::*;
#(
  parameter int AXIS_DWIDTH = 128,
  parameter int PIXEL_WIDTH = 8,
  parameter int COLS        = 1280,
  parameter int ROWS        = 1024
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [AXIS_DWIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [AXIS_DWIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  input  logic                   err_clr,
  output logic                   err_short,
  output logic                   err_long,
  output logic                   err_sof,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int BPL = beats_per_line(COLS, PIXEL_WIDTH, AXIS_DWIDTH);
  localparam int CW  = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t                 state, state_nx;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row, out_row;
  logic                   last_col, last_row, frame_done;
  logic                   pipe_rdy, ld, fwd, ld_user;
  logic [AXIS_DWIDTH-1:0] ld_data;
  logic                   set_short, set_long, set_sof;

  // col/row track the position of the next beat to be loaded into the output stage
  assign last_col   = (col == CW'(BPL - 1));
  assign last_row   = (row == RW'(ROWS - 1));
  // DROP is only ever entered at a line wrap, so row==0 there means the frame is done
  assign frame_done = (row == '0);

  always_comb begin
    state_nx      = state;
    s_axis_tready = 1'b0;
    ld            = 1'b0;
    fwd           = 1'b0;
    ld_data       = '0;
    ld_user       = 1'b0;
    set_short     = 1'b0;
    set_long      = 1'b0;
    set_sof       = 1'b0;
    case (state)
      WAIT_SOF: begin
        s_axis_tready = pipe_rdy || !s_axis_tuser;
        fwd           = s_axis_tvalid && s_axis_tuser && pipe_rdy;
        ld_user       = 1'b1;
      end
      PASS: begin
        if (s_axis_tvalid && s_axis_tuser) begin
          set_sof  = 1'b1;
          state_nx = PAD_FRAME;
        end else begin
          s_axis_tready = pipe_rdy;
          fwd           = s_axis_tvalid && pipe_rdy;
        end
      end
      PAD_LINE: begin
        ld = pipe_rdy;
        if (pipe_rdy && last_col) state_nx = last_row ? WAIT_SOF : PASS;
      end
      DROP: begin
        s_axis_tready = !s_axis_tuser;
        if (s_axis_tvalid && s_axis_tuser) begin
          if (frame_done) state_nx = WAIT_SOF;
          else begin
            set_sof  = 1'b1;
            state_nx = PAD_FRAME;
          end
        end else if (s_axis_tvalid && s_axis_tlast) begin
          state_nx = frame_done ? WAIT_SOF : PASS;
        end
      end
      PAD_FRAME: begin
        ld = pipe_rdy;
        if (pipe_rdy && last_col && last_row) state_nx = WAIT_SOF;
      end
      default: state_nx = WAIT_SOF;
    endcase

    if (fwd) begin
      ld      = 1'b1;
      ld_data = s_axis_tdata;
      if (s_axis_tlast && !last_col) begin
        set_short = 1'b1;
        state_nx  = PAD_LINE;
      end else if (last_col && !s_axis_tlast) begin
        set_long = 1'b1;
        state_nx = DROP;
      end else if (last_col && last_row) begin
        state_nx = WAIT_SOF;
      end else begin
        state_nx = PASS;
      end
    end

    if (areset) s_axis_tready = 1'b0;
  end

  axis_pipe_reg #(.DW(AXIS_DWIDTH)) u_pipe (
    .clk      (aclk),
    .rst      (areset),
    .in_valid (ld),
    .in_ready (pipe_rdy),
    .in_data  (ld_data),
    .in_last  (last_col),
    .in_user  (ld_user),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready),
    .out_data (m_axis_tdata),
    .out_last (m_axis_tlast),
    .out_user (m_axis_tuser)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= WAIT_SOF;
      col       <= '0;
      row       <= '0;
      out_row   <= '0;
      frame_cnt <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      err_sof   <= 1'b0;
    end else begin
      state <= state_nx;
      if (ld) begin
        col <= last_col ? '0 : col + CW'(1);
        if (last_col) row <= last_row ? '0 : row + RW'(1);
      end
      // frames are counted when their final beat actually leaves
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
        if (out_row == RW'(ROWS - 1)) begin
          out_row   <= '0;
          frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end else begin
          out_row <= out_row + RW'(1);
        end
      end
      err_short <= set_short || (err_short && !err_clr);
      err_long  <= set_long  || (err_long  && !err_clr);
      err_sof   <= set_sof   || (err_sof   && !err_clr);
    end
  end

endmodule

// File: tb/tb_remap_frame_sync.sv
// Bench for remap_frame_sync: 4x4-beat frames, stream-level reference model
// built from line/frame segmentation of the input beat list.
module tb_remap_frame_sync;

  localparam int DW   = 128;
  localparam int PW   = 8;
  localparam int COLS = 64;
  localparam int ROWS = 4;
  localparam int BPL  = COLS * PW / DW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  logic          aclk = 1'b0, areset = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tuser = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic          m_axis_tready = 1'b1;
  logic          err_clr = 1'b0;
  logic          err_short, err_long, err_sof;
  logic [15:0]   frame_cnt;

  remap_frame_sync #(.AXIS_DWIDTH(DW), .PIXEL_WIDTH(PW), .COLS(COLS), .ROWS(ROWS)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .err_clr(err_clr), .err_short(err_short), .err_long(err_long), .err_sof(err_sof),
    .frame_cnt(frame_cnt)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  beat_t in_q[$], exp_q[$], got_q[$];
  int    in_cyc[$], out_cyc[$];
  int    n_chk = 0, n_fail = 0, exp_fc = 0, m_frames;
  bit    m_short, m_long, m_sof;
  bit    stall_prev = 0;
  logic [DW+2:0] held;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: collects handshaken beats and checks a stalled beat is held
  always @(negedge aclk) begin
    if (areset) stall_prev = 0;
    else begin
      beat_t b;
      if (stall_prev) chk("stall_hold", 160'({m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}), 160'(held));
      if (m_axis_tvalid && m_axis_tready) begin
        b.data = m_axis_tdata; b.last = m_axis_tlast; b.user = m_axis_tuser;
        got_q.push_back(b);
        out_cyc.push_back(cyc);
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      held       = {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser};
    end
  end

  task automatic add_line(input int len, input bit with_last, input bit sof);
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.data = {$urandom(), $urandom(), $urandom(), $urandom()};
      b.last = with_last && (k == len - 1);
      b.user = sof && (k == 0);
      in_q.push_back(b);
    end
  endtask

  task automatic add_frame_clean();
    for (int r = 0; r < ROWS; r++) add_line(BPL, 1'b1, r == 0);
  endtask

  // Reference: split input at SOF beats into frames, each frame into lines at
  // tlast; emit ROWS lines of exactly BPL beats, zero filled where missing.
  task automatic run_model();
    int    i, j, n, len;
    bit    got_last, pad_rest;
    beat_t lq[$];
    beat_t b;
    exp_q.delete();
    m_short = 0; m_long = 0; m_sof = 0; m_frames = 0;
    n = in_q.size();
    i = 0;
    while (i < n && !in_q[i].user) i++;
    while (i < n) begin
      j = i;
      pad_rest = 0;
      for (int r = 0; r < ROWS; r++) begin
        lq.delete();
        got_last = 0;
        if (!pad_rest) begin
          while (j < n && !(in_q[j].user && j != i) && !got_last) begin
            lq.push_back(in_q[j]);
            got_last = in_q[j].last;
            j++;
          end
          len = lq.size();
          if (got_last) begin
            if (len < BPL) m_short = 1;
            if (len > BPL) m_long = 1;
          end else if (len >= BPL) begin
            m_long = 1;
          end else begin
            if (j < n) m_sof = 1;
            pad_rest = 1;
          end
        end
        for (int c = 0; c < BPL; c++) begin
          b.data = (c < lq.size()) ? lq[c].data : '0;
          b.last = (c == BPL - 1);
          b.user = (r == 0 && c == 0);
          exp_q.push_back(b);
        end
      end
      m_frames++;
      while (j < n && !in_q[j].user) j++;
      i = j;
    end
  endtask

  task automatic drive(input bit bubbles, input bit bp, input int stop_after);
    int idx = 0, t = 0;
    bit acc = 1;
    got_q.delete(); in_cyc.delete(); out_cyc.delete();
    while (idx < in_q.size() && t < 4000 && !(stop_after > 0 && got_q.size() >= stop_after)) begin
      if (acc || !s_axis_tvalid) s_axis_tvalid = bubbles ? ($urandom_range(3) != 0) : 1'b1;
      s_axis_tdata  = in_q[idx].data;
      s_axis_tlast  = in_q[idx].last;
      s_axis_tuser  = in_q[idx].user;
      m_axis_tready = bp ? !m_axis_tready : 1'b1;
      @(negedge aclk); #1;
      acc = s_axis_tvalid && s_axis_tready;
      if (acc) begin
        in_cyc.push_back(cyc);
        idx++;
      end
      @(posedge aclk); #1;
      t++;
    end
    s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tuser = 0;
    if (stop_after > 0) return;
    while (got_q.size() < exp_q.size() && t < 4000) begin
      m_axis_tready = bp ? !m_axis_tready : 1'b1;
      @(posedge aclk); #1;
      t++;
    end
    m_axis_tready = 1;
    repeat (6) @(posedge aclk);
    #1;
    chk("no_timeout", 160'(t < 4000), 160'(1));
  endtask

  task automatic compare(input string tag);
    chk($sformatf("%s beat_count", tag), 160'(got_q.size()), 160'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk($sformatf("%s beat%0d", tag, k), 160'(got_q[k]), 160'(exp_q[k]));
    chk($sformatf("%s flags", tag), 160'({err_short, err_long, err_sof}), 160'({m_short, m_long, m_sof}));
    exp_fc += m_frames;
    chk($sformatf("%s frame_cnt", tag), 160'(frame_cnt), 160'(exp_fc));
  endtask

  task automatic clear_flags();
    err_clr = 1;
    @(posedge aclk); #1;
    err_clr = 0;
    chk("err_clr", 160'({err_short, err_long, err_sof}), 160'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_ctrl", 160'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, s_axis_tready, err_short, err_long, err_sof}), 160'(0));
    chk("reset_data", 160'({m_axis_tdata, frame_cnt}), 160'(0));
    areset = 0;
    @(posedge aclk); #1;
    chk("idle_ready", 160'(s_axis_tready), 160'(1));

    // clean frame, with 1-cycle latency per beat
    clear_flags();
    in_q.delete(); add_frame_clean(); run_model(); drive(0, 0, 0); compare("clean");
    if (in_cyc.size() == BPL * ROWS && out_cyc.size() == BPL * ROWS)
      for (int k = 0; k < BPL * ROWS; k++) chk($sformatf("latency%0d", k), 160'(out_cyc[k]), 160'(in_cyc[k] + 1));
    else chk("latency_samples", 160'(out_cyc.size()), 160'(BPL * ROWS));

    // short line 1
    clear_flags();
    in_q.delete();
    add_line(4, 1, 1); add_line(2, 1, 0); add_line(4, 1, 0); add_line(4, 1, 0);
    run_model(); drive(0, 0, 0); compare("short");

    // long line 0
    clear_flags();
    in_q.delete();
    add_line(6, 1, 1); add_line(4, 1, 0); add_line(4, 1, 0); add_line(4, 1, 0);
    run_model(); drive(0, 0, 0); compare("long");

    // early SOF after 9 beats, then a full frame
    clear_flags();
    in_q.delete();
    add_line(4, 1, 1); add_line(4, 1, 0); add_line(1, 0, 0); add_frame_clean();
    run_model(); drive(0, 0, 0); compare("early_sof");

    // garbage before the frame
    clear_flags();
    in_q.delete();
    for (int k = 0; k < 5; k++) add_line(1, $urandom_range(1) == 1, 0);
    add_frame_clean();
    run_model(); drive(0, 0, 0); compare("garbage");

    // random geometry with input bubbles and output backpressure
    clear_flags();
    in_q.delete();
    for (int f = 0; f < 3; f++) begin
      int nl = $urandom_range(5, 2);
      for (int l = 0; l < nl; l++) add_line($urandom_range(6, 1), $urandom_range(3) != 0, l == 0);
    end
    add_frame_clean();
    run_model(); drive(1, 1, 0); compare("random");

    // backpressure, then reset after 6 output beats
    in_q.delete(); add_frame_clean(); run_model(); drive(0, 1, 6);
    chk("pre_reset_count", 160'(got_q.size()), 160'(6));
    for (int k = 0; k < 6 && k < got_q.size(); k++)
      chk($sformatf("pre_reset beat%0d", k), 160'(got_q[k]), 160'(exp_q[k]));
    areset = 1;
    m_axis_tready = 1;
    @(posedge aclk); #1;
    chk("mid_reset_ctrl", 160'({m_axis_tvalid, m_axis_tlast, m_axis_tuser, s_axis_tready, err_short, err_long, err_sof}), 160'(0));
    chk("mid_reset_data", 160'({m_axis_tdata, frame_cnt}), 160'(0));
    areset = 0;
    exp_fc = 0;
    in_q.delete();
    add_line(2, 1, 0); add_line(4, 1, 0); add_frame_clean();
    run_model(); drive(0, 0, 0); compare("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
